// File: rtl/mod_rebuild.sv
// mod_rebuild: rebuilds A = Q*B + R by 32-step shift-add.
// Ports:
//   clk, reset (sync, active-high), start, Q, B, R in
//   Result, done, busy, overflow, rem_err out
module mod_rebuild (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Q,
    input  logic [31:0] B,
    input  logic [31:0] R,
    output logic [31:0] Result,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        rem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_count;
    logic        r_rem_flag;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_rem_err;

    logic [63:0] w_acc_next;
    logic        w_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_count == 5'd31);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start)  w_next = S_RUN;
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= 64'd0;
            r_mcand    <= 64'd0;
            r_mplier   <= 32'd0;
            r_count    <= 5'd0;
            r_rem_flag <= 1'b0;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_rem_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= {32'd0, R};
                        r_mcand    <= {32'd0, B};
                        r_mplier   <= Q;
                        r_count    <= 5'd0;
                        r_rem_flag <= (R >= B);
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                    // Final iteration: publish the sum including this step.
                    if (w_last) begin
                        r_result   <= w_acc_next[31:0];
                        r_overflow <= |w_acc_next[63:32];
                        r_rem_err  <= r_rem_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result   = r_result;
    assign overflow = r_overflow;
    assign rem_err  = r_rem_err;
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state == S_RUN);

endmodule
